// File: rtl/cordic_rotate_seq_if.sv
// Request/result bundle for the sequential rotation-mode CORDIC.
// Master drives the request side, slave returns busy and the result.
interface cordic_rotate_seq_if #(
    parameter int IW = 12,
    parameter int OW = 12,
    parameter int PW = 19
);
    logic                 i_valid;
    logic signed [IW-1:0] i_mag;
    logic [PW-1:0]        i_phase;
    logic                 i_aux;
    logic                 o_busy;
    logic                 o_valid;
    logic signed [OW-1:0] o_x;
    logic signed [OW-1:0] o_y;
    logic                 o_aux;

    modport master (
        output i_valid, i_mag, i_phase, i_aux,
        input  o_busy, o_valid, o_x, o_y, o_aux
    );

    modport slave (
        input  i_valid, i_mag, i_phase, i_aux,
        output o_busy, o_valid, o_x, o_y, o_aux
    );
endinterface

// File: rtl/cordic_rotate_seq.sv
// Polar-to-rectangular CORDIC, rotation mode, one micro-rotation per clock.
// Gain is left uncompensated; phase uses 2^PW per full circle.
module cordic_rotate_seq #(
    parameter int IW      = 12,
    parameter int OW      = 12,
    parameter int WW      = 18,
    parameter int PW      = 19,
    parameter int NSTAGES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    cordic_rotate_seq_if.slave  bus
);
    localparam int CW   = $clog2(NSTAGES);
    localparam int SH   = WW - IW - 2;
    localparam int DROP = WW - 1 - OW;
    localparam int HALF = 1 << (DROP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_ROUND
    } state_t;

    state_t               state;
    logic [CW-1:0]        k;
    logic signed [WW-1:0] x;
    logic signed [WW-1:0] y;
    logic [PW-1:0]        z;
    logic                 aux_r;

    logic                 accept;
    logic [PW-1:0]        ph_off;
    logic [1:0]           q;
    logic [PW-1:0]        z0;
    logic signed [WW-1:0] e;
    logic [CW:0]          s;
    logic signed [WW-1:0] xs;
    logic signed [WW-1:0] ys;

    function automatic logic [PW-1:0] atan_tab(input logic [CW-1:0] idx);
        logic [PW-1:0] a;
        case (idx)
            4'd0:    a = PW'(19'h09720);
            4'd1:    a = PW'(19'h04fd9);
            4'd2:    a = PW'(19'h02888);
            4'd3:    a = PW'(19'h01458);
            4'd4:    a = PW'(19'h00a2e);
            4'd5:    a = PW'(19'h00517);
            4'd6:    a = PW'(19'h0028b);
            4'd7:    a = PW'(19'h00145);
            4'd8:    a = PW'(19'h000a2);
            4'd9:    a = PW'(19'h00051);
            4'd10:   a = PW'(19'h00028);
            4'd11:   a = PW'(19'h00014);
            4'd12:   a = PW'(19'h0000a);
            4'd13:   a = PW'(19'h00005);
            4'd14:   a = PW'(19'h00002);
            default: a = PW'(19'h00001);
        endcase
        return a;
    endfunction

    // Ties go to the even result: bias by one less when the kept LSB is 0.
    function automatic logic signed [OW-1:0] rnd(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] t;
        t = v + (v[DROP] ? WW'(HALF) : WW'(HALF - 1));
        return t[WW-2:DROP];
    endfunction

    assign accept = bus.i_valid && (state == S_IDLE || state == S_ROUND);

    // Fold the phase into [-45, +45) deg and pre-rotate by whole quadrants.
    assign ph_off = bus.i_phase + PW'(1 << (PW - 3));
    assign q      = ph_off[PW-1:PW-2];
    assign z0     = bus.i_phase - {q, {(PW-2){1'b0}}};
    assign e      = {{2{bus.i_mag[IW-1]}}, bus.i_mag, {SH{1'b0}}};

    assign s  = {1'b0, k} + (CW+1)'(1);
    assign xs = x >>> s;
    assign ys = y >>> s;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            k           <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            aux_r       <= 1'b0;
            bus.o_busy  <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_x     <= '0;
            bus.o_y     <= '0;
            bus.o_aux   <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;

            if (state == S_ROUND) begin
                bus.o_x     <= rnd(x);
                bus.o_y     <= rnd(y);
                bus.o_aux   <= aux_r;
                bus.o_valid <= 1'b1;
            end

            if (accept) begin
                aux_r      <= bus.i_aux;
                z          <= z0;
                k          <= '0;
                state      <= S_ROT;
                bus.o_busy <= 1'b1;
                case (q)
                    2'd0: begin x <= e;  y <= '0; end
                    2'd1: begin x <= '0; y <= e;  end
                    2'd2: begin x <= -e; y <= '0; end
                    default: begin x <= '0; y <= -e; end
                endcase
            end else begin
                case (state)
                    S_ROT: begin
                        if (!z[PW-1]) begin
                            x <= x - ys;
                            y <= y + xs;
                            z <= z - atan_tab(k);
                        end else begin
                            x <= x + ys;
                            y <= y - xs;
                            z <= z + atan_tab(k);
                        end
                        k <= k + 1'b1;
                        if (k == CW'(NSTAGES - 1))
                            state <= S_ROUND;
                    end
                    S_ROUND: begin
                        state      <= S_IDLE;
                        bus.o_busy <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cordic_rotate_seq.sv
// Directed bench for cordic_rotate_seq: vector table plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_cordic_rotate_seq;
    logic clk;
    logic rst;

    cordic_rotate_seq_if bus ();

    cordic_rotate_seq dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [11:0] mag;
        logic [18:0]        ph;
        logic               aux;
        int                 ex;
        int                 ey;
    } vec_t;

    vec_t tv[11];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        n_cmp++;
        if (act - exp > tol || exp - act > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic run_op(input logic signed [11:0] mag, input logic [18:0] ph,
                          input logic aux, output int lat, output int bcnt);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_mag   = mag;
        bus.i_phase = ph;
        bus.i_aux   = aux;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.o_valid && lat < 40) begin
            if (bus.o_busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (bus.o_busy) bcnt++;
    endtask

    int lat, bcnt, cnt, cyc, cx, cy, ca;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tv[0]  = '{12'sd1024,  19'h00000, 1'b0,   596,     0};
        tv[1]  = '{12'sd1024,  19'h20000, 1'b1,     0,   596};
        tv[2]  = '{12'sd1024,  19'h40000, 1'b0,  -596,     0};
        tv[3]  = '{12'sd1024,  19'h60000, 1'b1,     0,  -596};
        tv[4]  = '{12'sd1024,  19'h10000, 1'b0,   421,   421};
        tv[5]  = '{12'sd1024,  19'h7FFFF, 1'b1,   596,     0};
        tv[6]  = '{-12'sd2048, 19'h00000, 1'b0, -1192,     0};
        tv[7]  = '{12'sd1024,  19'h30000, 1'b1,  -422,   422};
        tv[8]  = '{12'sd2047,  19'h00000, 1'b0,  1192,     0};
        tv[9]  = '{-12'sd2048, 19'h20000, 1'b1,     0, -1192};
        tv[10] = '{12'sd512,   19'h50000, 1'b0,  -211,  -211};

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_mag   = '0;
        bus.i_phase = '0;
        bus.i_aux   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",  int'(bus.o_busy),  0, 0);
        chk("rst_valid", int'(bus.o_valid), 0, 0);
        chk("rst_x",     int'(bus.o_x),     0, 0);
        chk("rst_y",     int'(bus.o_y),     0, 0);
        chk("rst_aux",   int'(bus.o_aux),   0, 0);

        for (int i = 0; i < 11; i++) begin
            run_op(tv[i].mag, tv[i].ph, tv[i].aux, lat, bcnt);
            chk($sformatf("v%0d_lat", i),  lat,               17, 0);
            chk($sformatf("v%0d_busy", i), bcnt,              17, 0);
            chk($sformatf("v%0d_x", i),    int'(bus.o_x),     tv[i].ex, 2);
            chk($sformatf("v%0d_y", i),    int'(bus.o_y),     tv[i].ey, 2);
            chk($sformatf("v%0d_aux", i),  int'(bus.o_aux),   int'(tv[i].aux), 0);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), int'(bus.o_valid), 0, 0);
            chk($sformatf("v%0d_hold", i),  int'(bus.o_x),     tv[i].ex, 2);
        end

        // Requests while busy must be dropped.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_mag   = 12'sd1024;
        bus.i_phase = 19'h00000;
        bus.i_aux   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        cnt = 0;
        cx  = 0;
        ca  = 0;
        for (int c = 1; c < 60; c++) begin
            if (c == 3 || c == 10) begin
                bus.i_valid = 1'b1;
                bus.i_phase = 19'h40000;
                bus.i_aux   = 1'b0;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.o_valid) begin
                cnt++;
                cx = int'(bus.o_x);
                ca = int'(bus.o_aux);
            end
        end
        bus.i_valid = 1'b0;
        chk("drop_count", cnt, 1,   0);
        chk("drop_x",     cx,  596, 2);
        chk("drop_aux",   ca,  1,   0);

        // Back-to-back: valid held high, tags alternate per accept.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_mag   = 12'sd1024;
        bus.i_phase = 19'h20000;
        bus.i_aux   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.i_aux = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus.o_valid && cyc < 40);
            chk($sformatf("b2b%0d_gap", r), cyc,             17,    0);
            chk($sformatf("b2b%0d_aux", r), int'(bus.o_aux), r % 2, 0);
            chk($sformatf("b2b%0d_y", r),   int'(bus.o_y),   596,   2);
            chk($sformatf("b2b%0d_busy", r), int'(bus.o_busy), 1,   0);
            bus.i_aux = logic'(r % 2);
        end
        bus.i_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.o_valid && cyc < 40);
        chk("b2b4_gap",  cyc,              17, 0);
        chk("b2b4_aux",  int'(bus.o_aux),  0,  0);
        chk("b2b4_idle", int'(bus.o_busy), 0,  0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_mag   = 12'sd1024;
        bus.i_phase = 19'h10000;
        bus.i_aux   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy",  int'(bus.o_busy),  0, 0);
        chk("mrst_valid", int'(bus.o_valid), 0, 0);
        chk("mrst_x",     int'(bus.o_x),     0, 0);
        chk("mrst_y",     int'(bus.o_y),     0, 0);
        chk("mrst_aux",   int'(bus.o_aux),   0, 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.o_valid) cnt++;
        end
        chk("mrst_novalid", cnt, 0, 0);
        run_op(12'sd1024, 19'h60000, 1'b1, lat, bcnt);
        chk("post_lat",  lat,             17,   0);
        chk("post_busy", bcnt,            17,   0);
        chk("post_x",    int'(bus.o_x),   0,    2);
        chk("post_y",    int'(bus.o_y),   -596, 2);
        chk("post_aux",  int'(bus.o_aux), 1,    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
